// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson/ring sequence generator.
// Optional build macro: JOHNSON_SELF_CORRECT_EN (see johnson_seq_gen).
package johnson_pkg;

    typedef enum logic {
        MODE_JOHNSON = 1'b0,
        MODE_RING    = 1'b1
    } mode_e;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Widest register the start_state helper can describe.
    localparam int MAX_WIDTH = 64;

    // Start code S0: all zeros for Johnson, a single one in bit 0 for ring.
    function automatic logic [MAX_WIDTH-1:0] start_state(input mode_e mode, input int width);
        logic [MAX_WIDTH-1:0] s;
        s = '0;
        if (mode == MODE_RING && width >= 1) begin
            s[0] = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/johnson_phase_dec.sv
// Combinational decoder: maps a shift-register code to its position in the
// forward sequence and flags whether the code belongs to the sequence at all.
module johnson_phase_dec
    import johnson_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int PH_W  = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            mode,
    output logic [PH_W-1:0]  phase,
    output logic             legal
);

    // Count ones, bit transitions and the set-bit index, then pick the mode's rule.
    always_comb begin
        int ones;
        int edges;
        int idx;
        ones  = 0;
        edges = 0;
        idx   = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + int'(q[i]);
            if (q[i]) begin
                idx = i;
            end
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (q[i] != q[i+1]) begin
                edges = edges + 1;
            end
        end
        if (mode == MODE_RING) begin
            phase = PH_W'(idx);
            legal = (ones == 1);
        end else begin
            phase = q[WIDTH-1] ? PH_W'(2 * WIDTH - ones) : PH_W'(ones);
            legal = (edges <= 1);
        end
    end

endmodule

// File: rtl/johnson_seq_gen.sv
// Parametrised Johnson / ring sequence generator with prescaler, direction
// control, parallel load, phase decode, wrap pulse and illegal-state flag.
// Build macro JOHNSON_SELF_CORRECT_EN enables legality checking, the err
// flag and recovery from illegal codes; without it err is tied low.
module johnson_seq_gen
    import johnson_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DIV_W = 8,
    localparam int PH_W  = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [PH_W-1:0]  phase,
    output logic             wrap,
    output logic             err
);

    mode_e            mode_in;
    mode_e            mode_q;
    logic [DIV_W-1:0] pc;
    logic [DIV_W-1:0] pc_nxt;
    logic             tick;
    logic             mode_change;
    logic [WIDTH-1:0] s0_new;
    logic [WIDTH-1:0] s0_cur;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             legal_cur;

    assign mode_in     = mode_e'(mode);
    assign mode_change = (mode_q != mode_in);
    assign tick        = en && (pc >= div);
    assign s0_new      = WIDTH'(start_state(mode_in, WIDTH));
    assign s0_cur      = WIDTH'(start_state(mode_q, WIDTH));

    // Phase and legality of the code currently held, in the mode it was built in.
    johnson_phase_dec #(.WIDTH(WIDTH)) u_dec_cur (
        .q     (q),
        .mode  (mode_q),
        .phase (phase),
        .legal (legal_cur)
    );

    // One step of the shift register in the current mode and direction.
    always_comb begin
        if (mode_q == MODE_RING) begin
            step_q = (dir == DIR_REV) ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};
        end else begin
            step_q = (dir == DIR_REV) ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};
        end
    end

    // Next state: mode change beats load, load beats a tick; the prescaler
    // restarts whenever the sequence is redirected.
    always_comb begin
        q_nxt    = q;
        pc_nxt   = pc;
        wrap_nxt = 1'b0;
        if (mode_change) begin
            q_nxt  = s0_new;
            pc_nxt = '0;
        end else if (load) begin
            q_nxt  = load_val;
            pc_nxt = '0;
        end else if (en) begin
            if (tick) begin
                pc_nxt = '0;
`ifdef JOHNSON_SELF_CORRECT_EN
                if (!legal_cur) begin
                    q_nxt = s0_cur;
                end else begin
                    q_nxt    = step_q;
                    wrap_nxt = (step_q == s0_cur);
                end
`else
                q_nxt    = step_q;
                wrap_nxt = (step_q == s0_cur);
`endif
            end else begin
                pc_nxt = pc + DIV_W'(1);
            end
        end
    end

    // Register the sequence state, prescaler, mode history and wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= s0_new;
            pc     <= '0;
            mode_q <= mode_in;
            wrap   <= 1'b0;
        end else begin
            q      <= q_nxt;
            pc     <= pc_nxt;
            mode_q <= mode_in;
            wrap   <= wrap_nxt;
        end
    end

`ifdef JOHNSON_SELF_CORRECT_EN
    logic                legal_nxt;
    logic [PH_W-1:0]     phase_nxt_unused;

    // Legality of the code about to be registered, judged in the incoming mode.
    johnson_phase_dec #(.WIDTH(WIDTH)) u_dec_nxt (
        .q     (q_nxt),
        .mode  (mode_in),
        .phase (phase_nxt_unused),
        .legal (legal_nxt)
    );

    // Flag registered alongside q so it describes the code q is about to hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= ~legal_nxt;
        end
    end
`else
    logic legal_unused;
    assign legal_unused = legal_cur;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_seq_gen.sv
// Self-checking bench for johnson_seq_gen (WIDTH = 4): a directed vector
// table followed by randomized traffic against a phase-index reference model.
module tb_johnson_seq_gen;

    localparam int W     = 4;
    localparam int DIV_W = 8;
    localparam int PH_W  = $clog2(2 * W);

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             mode;
    logic             dir;
    logic [DIV_W-1:0] div;
    logic             load;
    logic [W-1:0]     load_val;
    logic [W-1:0]     q;
    logic [PH_W-1:0]  phase;
    logic             wrap;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;

    johnson_seq_gen #(.WIDTH(W), .DIV_W(DIV_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .div      (div),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .phase    (phase),
        .wrap     (wrap),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             en;
        logic             mode;
        logic             dir;
        logic [DIV_W-1:0] div;
        logic             load;
        logic [W-1:0]     load_val;
        logic [W-1:0]     exp_q;
        int               exp_phase;
        logic             exp_wrap;
        logic             exp_err;
        bit               chk_phase;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic r, logic e, logic m, logic d, int dv, logic l,
                                 logic [W-1:0] lv, logic [W-1:0] eq, int ep,
                                 logic ew, logic ee, bit cp);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.dir = d; v.div = DIV_W'(dv);
        v.load = l; v.load_val = lv; v.exp_q = eq; v.exp_phase = ep;
        v.exp_wrap = ew; v.exp_err = ee; v.chk_phase = cp;
        return v;
    endfunction

    // Sequence length for a mode.
    function automatic int seq_len(logic md);
        return md ? W : 2 * W;
    endfunction

    // Code that sits at position p of the forward sequence.
    function automatic logic [W-1:0] code_of(logic md, int p);
        int v;
        if (md) v = 1 << p;
        else if (p <= W) v = (1 << p) - 1;
        else v = ((1 << W) - 1) - ((1 << (p - W)) - 1);
        return W'(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst      = v.rst;
        en       = v.en;
        mode     = v.mode;
        dir      = v.dir;
        div      = v.div;
        load     = v.load;
        load_val = v.load_val;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: position in the sequence rather than a bit pattern.
    int   m_phase;
    int   m_pc;
    logic m_mode_q;
    logic m_wrap;
    int   ld_phase;

    initial begin
        // Directed vectors: Johnson count, reverse, ring, priority, prescaler, illegal code.
        vecs.push_back(mkv(1,0,0,0,0,0,4'h0, 4'b0000,0,0,0,1));
        vecs.push_back(mkv(0,1,0,0,0,0,4'h0, 4'b0001,1,0,0,1));
        vecs.push_back(mkv(0,1,0,0,0,0,4'h0, 4'b0011,2,0,0,1));
        vecs.push_back(mkv(0,1,0,0,0,0,4'h0, 4'b0111,3,0,0,1));
        vecs.push_back(mkv(0,1,0,0,0,0,4'h0, 4'b1111,4,0,0,1));
        vecs.push_back(mkv(0,1,0,0,0,0,4'h0, 4'b1110,5,0,0,1));
        vecs.push_back(mkv(0,1,0,0,0,0,4'h0, 4'b1100,6,0,0,1));
        vecs.push_back(mkv(0,1,0,0,0,0,4'h0, 4'b1000,7,0,0,1));
        vecs.push_back(mkv(0,1,0,0,0,0,4'h0, 4'b0000,0,1,0,1));
        vecs.push_back(mkv(1,0,0,1,0,0,4'h0, 4'b0000,0,0,0,1));
        vecs.push_back(mkv(0,1,0,1,0,0,4'h0, 4'b1000,7,0,0,1));
        vecs.push_back(mkv(0,1,0,1,0,0,4'h0, 4'b1100,6,0,0,1));
        vecs.push_back(mkv(0,1,1,1,0,0,4'h0, 4'b0001,0,0,0,1));
        vecs.push_back(mkv(0,1,1,1,0,0,4'h0, 4'b1000,3,0,0,1));
        vecs.push_back(mkv(0,1,1,1,0,0,4'h0, 4'b0100,2,0,0,1));
        vecs.push_back(mkv(0,1,1,1,0,0,4'h0, 4'b0010,1,0,0,1));
        vecs.push_back(mkv(0,1,1,1,0,0,4'h0, 4'b0001,0,1,0,1));
        vecs.push_back(mkv(1,0,0,0,0,0,4'h0, 4'b0000,0,0,0,1));
        vecs.push_back(mkv(0,1,0,0,2,0,4'h0, 4'b0000,0,0,0,1));
        vecs.push_back(mkv(0,1,0,0,2,0,4'h0, 4'b0000,0,0,0,1));
        vecs.push_back(mkv(0,1,0,0,2,1,4'h3, 4'b0011,2,0,0,1));
        vecs.push_back(mkv(0,1,0,0,2,0,4'h0, 4'b0011,2,0,0,1));
        vecs.push_back(mkv(0,1,0,0,2,0,4'h0, 4'b0011,2,0,0,1));
        vecs.push_back(mkv(0,1,0,0,2,0,4'h0, 4'b0111,3,0,0,1));
        vecs.push_back(mkv(1,1,0,0,2,1,4'h3, 4'b0000,0,0,0,1));
        vecs.push_back(mkv(0,1,0,0,2,0,4'h0, 4'b0000,0,0,0,1));
        vecs.push_back(mkv(0,1,0,0,2,0,4'h0, 4'b0000,0,0,0,1));
        vecs.push_back(mkv(0,1,0,0,2,0,4'h0, 4'b0001,1,0,0,1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mkv(0,0,0,0,2,0,4'h0, 4'b0001,1,0,0,1));
        vecs.push_back(mkv(0,1,0,0,2,0,4'h0, 4'b0001,1,0,0,1));
        vecs.push_back(mkv(0,1,0,0,2,0,4'h0, 4'b0001,1,0,0,1));
        vecs.push_back(mkv(0,1,0,0,2,0,4'h0, 4'b0011,2,0,0,1));
        vecs.push_back(mkv(0,1,0,0,5,0,4'h0, 4'b0011,2,0,0,1));
        vecs.push_back(mkv(0,1,0,0,5,0,4'h0, 4'b0011,2,0,0,1));
        vecs.push_back(mkv(0,1,0,0,5,0,4'h0, 4'b0011,2,0,0,1));
        vecs.push_back(mkv(0,1,0,0,5,0,4'h0, 4'b0011,2,0,0,1));
        vecs.push_back(mkv(0,1,0,0,1,0,4'h0, 4'b0111,3,0,0,1));
        vecs.push_back(mkv(0,1,0,0,1,0,4'h0, 4'b0111,3,0,0,1));
        vecs.push_back(mkv(0,1,0,0,1,0,4'h0, 4'b1111,4,0,0,1));
`ifdef JOHNSON_SELF_CORRECT_EN
        vecs.push_back(mkv(0,0,0,0,0,1,4'h5, 4'b0101,0,0,1,0));
        vecs.push_back(mkv(0,1,0,0,0,0,4'h0, 4'b0000,0,0,0,1));
`else
        vecs.push_back(mkv(0,0,0,0,0,1,4'h5, 4'b0101,0,0,0,0));
        vecs.push_back(mkv(0,1,0,0,0,0,4'h0, 4'b1011,0,0,0,0));
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d q", i), int'(q), int'(vecs[i].exp_q));
            checkOutput($sformatf("vec%0d wrap", i), int'(wrap), int'(vecs[i].exp_wrap));
            checkOutput($sformatf("vec%0d err", i), int'(err), int'(vecs[i].exp_err));
            if (vecs[i].chk_phase)
                checkOutput($sformatf("vec%0d phase", i), int'(phase), vecs[i].exp_phase);
        end

        // Randomized traffic against the phase-index model (legal loads only).
        m_phase  = 0;
        m_pc     = 0;
        m_mode_q = 1'b0;
        mode     = 1'b0;
        div      = '0;
        for (int c = 0; c < 3000; c++) begin
            rst = (c == 0) || ($urandom_range(63, 0) == 0);
            en  = ($urandom_range(9, 0) < 7);
            if ($urandom_range(31, 0) == 0) mode = ~mode;
            dir = 1'($urandom_range(1, 0));
            if ($urandom_range(15, 0) == 0) div = DIV_W'($urandom_range(3, 0));
            load     = ($urandom_range(15, 0) == 0);
            ld_phase = int'($urandom_range(seq_len(mode) - 1, 0));
            load_val = code_of(mode, ld_phase);
            @(posedge clk);
            m_wrap = 1'b0;
            if (rst) begin
                m_mode_q = mode; m_phase = 0; m_pc = 0;
            end else if (mode != m_mode_q) begin
                m_mode_q = mode; m_phase = 0; m_pc = 0;
            end else if (load) begin
                m_phase = ld_phase; m_pc = 0;
            end else if (en) begin
                if (m_pc >= int'(div)) begin
                    m_pc = 0;
                    if (dir) m_phase = (m_phase + seq_len(m_mode_q) - 1) % seq_len(m_mode_q);
                    else     m_phase = (m_phase + 1) % seq_len(m_mode_q);
                    m_wrap = (m_phase == 0);
                end else begin
                    m_pc = m_pc + 1;
                end
            end
            #1;
            checkOutput($sformatf("rnd%0d q", c), int'(q), int'(code_of(m_mode_q, m_phase)));
            checkOutput($sformatf("rnd%0d phase", c), int'(phase), m_phase);
            checkOutput($sformatf("rnd%0d wrap", c), int'(wrap), int'(m_wrap));
            checkOutput($sformatf("rnd%0d err", c), int'(err), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
